// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Pops words from an upstream FIFO with a fixed 1-cycle read latency and
// presents them on a valid/ready stream through a 3-entry in-order skid buffer.
// The skid buffer lets the pop request depend only on registered occupancy,
// so there is no combinational path from m_ready to fifo_r_enable.
// Optional burst framing (beat counter driving m_last) is compiled only when
// the macro FIFO_STREAM_READER_LAST_EN is defined; otherwise m_last is tied to 0.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_enable,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int DEPTH = 3;

    if (BURST_LEN < 2) begin : g_bad_burst
        $error("fifo_stream_reader: BURST_LEN must be at least 2");
    end

    logic [1:0]            occ;
    logic [1:0]            head;
    logic [1:0]            tail;
    logic                  inf;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [2:0]            pending;
    logic                  capture;
    logic                  transfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Words already buffered plus the one in flight; a pop is only issued
    // when a free slot is guaranteed for its data next cycle.
    assign pending  = {1'b0, occ} + {2'b0, inf};

    // Gated with rst so no pop escapes while reset is held.
    assign fifo_r_enable = rst & enable & ~fifo_empty & (pending < 3'd3);

    assign capture  = inf;
    assign transfer = m_valid & m_ready;
    assign m_valid  = (occ != 2'd0);
    assign m_data   = mem[head];

    // Pop latency tracking, occupancy and ring pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inf  <= 1'b0;
            occ  <= 2'd0;
            head <= 2'd0;
            tail <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every update here sees the
            // pre-edge values of occ/head/tail, regardless of statement order.
            inf <= fifo_r_enable;
            if (capture)  tail <= ptr_inc(tail);
            if (transfer) head <= ptr_inc(head);
            case ({capture, transfer})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Skid buffer storage: the in-flight word lands at the tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: resetting storage is affordable for three registers and
            // makes m_data read 0 in reset; a large RAM would not be reset.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (capture) begin
            mem[tail] <= fifo_data;
        end
    end

`ifdef FIFO_STREAM_READER_LAST_EN
    localparam int BW = $clog2(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    logic [BW-1:0] beat;

    // Beat position within the current burst, advanced per accepted word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat <= '0;
        end else if (transfer) begin
            beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
        end
    end

    assign m_last = m_valid & (beat == LAST_BEAT);
`else
    assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader.
// The bench plays the upstream FIFO (queue src, data one cycle after a pop)
// and keeps a reference model as a queue of buffered words plus an in-flight
// word. Honours FIFO_STREAM_READER_LAST_EN for the expected m_last.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int BL = 4;

    logic          clk        = 1'b0;
    logic          rst        = 1'b0;
    logic          enable     = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          m_ready    = 1'b0;
    logic          fifo_r_enable;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;

    int checks = 0;
    int errors = 0;

    // Upstream FIFO contents and reference model state.
    logic [DW-1:0] src[$];
    logic [DW-1:0] buf_q[$];
    bit            pend_valid = 1'b0;
    logic [DW-1:0] pend_data  = '0;
    int            beat       = 0;
    logic [DW-1:0] seq        = 8'h01;

    // Observed stream activity for directed scenario checks.
    logic [DW-1:0] obs_data[$];
    bit            obs_last[$];
    int            pops_seen = 0;

    fifo_stream_reader #(
        .DATA_WIDTH(DW),
        .BURST_LEN (BL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_r_enable(fifo_r_enable),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            src.push_back(seq);
            seq++;
        end
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
        pops_seen = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic cycle(input bit en, input bit rdy);
        bit exp_pop;
        bit exp_valid;
        bit exp_last;
        @(negedge clk);
        enable     = en;
        m_ready    = rdy;
        fifo_empty = (src.size() == 0);
        fifo_data  = pend_valid ? pend_data : DW'($urandom);
        #1;
        exp_pop   = en && (src.size() != 0) && ((buf_q.size() + int'(pend_valid)) < 3);
        exp_valid = (buf_q.size() != 0);
`ifdef FIFO_STREAM_READER_LAST_EN
        exp_last  = exp_valid && (beat == BL - 1);
`else
        exp_last  = 1'b0;
`endif
        check("fifo_r_enable", 32'(fifo_r_enable), 32'(exp_pop));
        check("m_valid", 32'(m_valid), 32'(exp_valid));
        check("m_last", 32'(m_last), 32'(exp_last));
        if (exp_valid) check("m_data", 32'(m_data), 32'(buf_q[0]));
        if (fifo_r_enable) pops_seen++;
        if (m_valid && rdy) begin
            obs_data.push_back(m_data);
            obs_last.push_back(m_last);
        end
        @(posedge clk);
        if (exp_valid && rdy) begin
            void'(buf_q.pop_front());
            beat = (beat + 1) % BL;
        end
        if (pend_valid) buf_q.push_back(pend_data);
        pend_valid = exp_pop;
        if (exp_pop) pend_data = src.pop_front();
    endtask

    // Hold reset for a cycle with pop conditions otherwise true, then release.
    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b0;
        enable     = 1'b1;
        m_ready    = 1'b1;
        fifo_empty = 1'b0;
        #1;
        check("rst_fifo_r_enable", 32'(fifo_r_enable), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        @(negedge clk);
        enable = 1'b0;
        rst    = 1'b1;
        buf_q.delete();
        pend_valid = 1'b0;
        beat       = 0;
    endtask

    initial begin
        logic [DW-1:0] stream_vals [4];
        logic [DW-1:0] first_exp;
        logic [7:0]    last_mask;
        logic [7:0]    exp_mask;

        stream_vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state.
        apply_reset();

        // Streaming: four words in four consecutive cycles, first valid two cycles after first pop.
        clear_obs();
        for (int i = 0; i < 4; i++) src.push_back(stream_vals[i]);
        repeat (6) cycle(1'b1, 1'b1);
        check("stream_count", 32'(obs_data.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < obs_data.size()) check("stream_data", 32'(obs_data[i]), 32'(stream_vals[i]));

        // Empty FIFO: no pops, nothing valid.
        clear_obs();
        repeat (5) cycle(1'b1, 1'b1);
        check("empty_pops", 32'(pops_seen), 32'd0);

        // Backpressure: exactly three pops, data frozen, then drained in order.
        clear_obs();
        push(8);
        repeat (6) cycle(1'b1, 1'b0);
        check("bp_pops", 32'(pops_seen), 32'd3);
        repeat (12) cycle(1'b1, 1'b1);
        check("bp_drained", 32'(obs_data.size()), 32'd8);

        // Enable drop one cycle after a pop: in-flight word still delivered.
        clear_obs();
        push(6);
        cycle(1'b1, 1'b1);
        repeat (6) cycle(1'b0, 1'b1);
        check("endrop_pops", 32'(pops_seen), 32'd1);
        check("endrop_delivered", 32'(obs_data.size()), 32'd1);

        // Framing: eight transfers after reset, m_last only on beats 3 and 7.
        apply_reset();
        src.delete();
        clear_obs();
        push(8);
        repeat (12) cycle(1'b1, 1'b1);
        check("frame_count", 32'(obs_data.size()), 32'd8);
        last_mask = '0;
        for (int i = 0; i < 8; i++)
            if (i < obs_last.size()) last_mask[i] = obs_last[i];
`ifdef FIFO_STREAM_READER_LAST_EN
        exp_mask = 8'h88;
`else
        exp_mask = 8'h00;
`endif
        check("frame_last_mask", 32'(last_mask), 32'(exp_mask));

        // Reset mid-operation with two buffered words and one in flight.
        clear_obs();
        push(6);
        repeat (3) cycle(1'b1, 1'b0);
        first_exp = src[0];
        apply_reset();
        clear_obs();
        repeat (10) cycle(1'b1, 1'b1);
        check("midrst_count", 32'(obs_data.size()), 32'd3);
        if (obs_data.size() > 0) begin
            check("midrst_first_data", 32'(obs_data[0]), 32'(first_exp));
            check("midrst_first_last", 32'(obs_last[0]), 32'd0);
        end

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            if (($urandom_range(0, 3) != 0) && (src.size() < 20)) src.push_back(DW'($urandom));
            cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
